// File: rtl/cmd_frame_decoder.sv
// cmd_frame_decoder: assembles write/read/ALU command frames from a byte strobe and
// issues one decoded command per frame. Define CMD_TIMEOUT_EN for the inter-byte timeout.
module cmd_frame_decoder #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  cmd_ready,
  output logic                  cmd_valid,
  output logic [1:0]            cmd_type,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [DATA_WIDTH-1:0] cmd_opa,
  output logic [DATA_WIDTH-1:0] cmd_opb,
  output logic [3:0]            cmd_fun,
  output logic                  frame_err
);

  localparam int unsigned FUN_WIDTH = 4;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_ADDR = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_ADDR = 3'd3;
  localparam logic [2:0] S_ALU_A   = 3'd4;
  localparam logic [2:0] S_ALU_B   = 3'd5;
  localparam logic [2:0] S_ALU_FUN = 3'd6;
  localparam logic [2:0] S_ISSUE   = 3'd7;

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] OP_ALU    = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] OP_ALU_NO = DATA_WIDTH'(8'hDD);

  localparam logic [1:0] T_WR     = 2'b00;
  localparam logic [1:0] T_RD     = 2'b01;
  localparam logic [1:0] T_ALU    = 2'b10;
  localparam logic [1:0] T_ALU_NO = 2'b11;

  // A zero timeout would abort every frame before its second byte.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [2:0]            r_state, w_state_nxt;
  logic                  r_with_ops, w_with_ops_nxt;
  logic                  r_cmd_valid, w_cmd_valid_nxt;
  logic [1:0]            r_cmd_type, w_cmd_type_nxt;
  logic [ADDR_WIDTH-1:0] r_cmd_addr, w_cmd_addr_nxt;
  logic [DATA_WIDTH-1:0] r_cmd_wdata, w_cmd_wdata_nxt;
  logic [DATA_WIDTH-1:0] r_cmd_opa, w_cmd_opa_nxt;
  logic [DATA_WIDTH-1:0] r_cmd_opb, w_cmd_opb_nxt;
  logic [FUN_WIDTH-1:0]  r_cmd_fun, w_cmd_fun_nxt;
  logic                  r_frame_err, w_frame_err_nxt;
  logic                  w_tmo;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_tmo_cnt;

  // Inter-byte watchdog; idle outside the byte-collecting states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_IDLE) || (r_state == S_ISSUE) || rx_valid ||
                 (w_state_nxt != r_state)) begin
      r_tmo_cnt <= '0;
    end else begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end
`endif

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_with_ops_nxt  = r_with_ops;
    w_cmd_type_nxt  = r_cmd_type;
    w_cmd_addr_nxt  = r_cmd_addr;
    w_cmd_wdata_nxt = r_cmd_wdata;
    w_cmd_opa_nxt   = r_cmd_opa;
    w_cmd_opb_nxt   = r_cmd_opb;
    w_cmd_fun_nxt   = r_cmd_fun;
    w_frame_err_nxt = 1'b0;
`ifdef CMD_TIMEOUT_EN
    w_tmo = (r_state != S_IDLE) && (r_state != S_ISSUE) && !rx_valid &&
            (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    w_tmo = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_WR:     w_state_nxt = S_WR_ADDR;
            OP_RD:     w_state_nxt = S_RD_ADDR;
            OP_ALU:    w_state_nxt = S_ALU_A;
            OP_ALU_NO: begin
              w_state_nxt    = S_ALU_FUN;
              w_with_ops_nxt = 1'b0;
            end
            default:   w_frame_err_nxt = 1'b1;
          endcase
        end
      end
      S_WR_ADDR: if (rx_valid) begin
        w_cmd_addr_nxt = rx_data[ADDR_WIDTH-1:0];
        w_state_nxt    = S_WR_DATA;
      end
      S_WR_DATA: if (rx_valid) begin
        w_cmd_wdata_nxt = rx_data;
        w_cmd_type_nxt  = T_WR;
        w_state_nxt     = S_ISSUE;
      end
      S_RD_ADDR: if (rx_valid) begin
        w_cmd_addr_nxt = rx_data[ADDR_WIDTH-1:0];
        w_cmd_type_nxt = T_RD;
        w_state_nxt    = S_ISSUE;
      end
      S_ALU_A: if (rx_valid) begin
        w_cmd_opa_nxt = rx_data;
        w_state_nxt   = S_ALU_B;
      end
      S_ALU_B: if (rx_valid) begin
        w_cmd_opb_nxt  = rx_data;
        w_with_ops_nxt = 1'b1;
        w_state_nxt    = S_ALU_FUN;
      end
      S_ALU_FUN: if (rx_valid) begin
        w_cmd_fun_nxt  = rx_data[FUN_WIDTH-1:0];
        w_cmd_type_nxt = r_with_ops ? T_ALU : T_ALU_NO;
        w_state_nxt    = S_ISSUE;
      end
      S_ISSUE: begin
        if (rx_valid)  w_frame_err_nxt = 1'b1;
        if (cmd_ready) w_state_nxt     = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // A byte in the same cycle always beats the timeout.
    if (w_tmo) begin
      w_state_nxt     = S_IDLE;
      w_frame_err_nxt = 1'b1;
    end
    w_cmd_valid_nxt = (w_state_nxt == S_ISSUE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_with_ops  <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_type  <= '0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_opa   <= '0;
      r_cmd_opb   <= '0;
      r_cmd_fun   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_with_ops  <= w_with_ops_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd_type  <= w_cmd_type_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_wdata <= w_cmd_wdata_nxt;
      r_cmd_opa   <= w_cmd_opa_nxt;
      r_cmd_opb   <= w_cmd_opb_nxt;
      r_cmd_fun   <= w_cmd_fun_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_type  = r_cmd_type;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_wdata = r_cmd_wdata;
  assign cmd_opa   = r_cmd_opa;
  assign cmd_opb   = r_cmd_opb;
  assign cmd_fun   = r_cmd_fun;
  assign frame_err = r_frame_err;

endmodule

// File: doc/cmd_frame_decoder.md
# cmd_frame_decoder

Byte-level command parser sitting directly downstream of the data synchronizer in the system clock domain. Each accepted byte arrives as a single-cycle `rx_valid` strobe with `rx_data` stable in the same cycle, as the synchronizer's enable pulse and sync bus. The block assembles multi-byte command frames (register write, register read, ALU with operands, ALU without operands) and presents one decoded command per frame to the system controller over a valid/ready handshake.

## Interface
- `DATA_WIDTH`, 8: byte width of `rx_data`, data and operands.
- `ADDR_WIDTH`, 4: register-file address width; taken from the address byte LSBs.
- `TIMEOUT_CYCLES`, 255: inter-byte timeout in clk cycles; used only with `CMD_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock. One clock domain only.
- `reset` in 1: asynchronous, active-high reset.
- `rx_valid` in 1: one-cycle strobe marking a new byte.
- `rx_data` in DATA_WIDTH: byte; sampled only when `rx_valid`=1.
- `cmd_ready` in 1: consumer accepts the command when `cmd_ready`=1 and `cmd_valid`=1.
- `cmd_valid` out 1: decoded command available.
- `cmd_type` out 2: 00 write, 01 read, 10 ALU with operands, 11 ALU without operands.
- `cmd_addr` out ADDR_WIDTH: register address (write/read).
- `cmd_wdata` out DATA_WIDTH: write data.
- `cmd_opa`, `cmd_opb` out DATA_WIDTH: ALU operands.
- `cmd_fun` out 4: ALU function, taken from the function byte LSBs.
- `frame_err` out 1: one-cycle pulse on a protocol error.

## Operation
States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, ISSUE. All transitions below occur on a byte (`rx_valid`=1) unless stated otherwise.
- IDLE:
  - 0xAA → WR_ADDR.
  - 0xBB → RD_ADDR.
  - 0xCC → ALU_A.
  - 0xDD → ALU_FUN.
  - Any other byte: stay in IDLE and pulse `frame_err`.
- WR_ADDR: latch `cmd_addr` → WR_DATA. WR_DATA: latch `cmd_wdata` → ISSUE, `cmd_type`=00.
- RD_ADDR: latch `cmd_addr` → ISSUE, `cmd_type`=01.
- ALU_A: latch `cmd_opa` → ALU_B. ALU_B: latch `cmd_opb` → ALU_FUN. ALU_FUN: latch `cmd_fun` → ISSUE, `cmd_type`=10 if entered from ALU_B, 11 if entered from IDLE.
- 0xDD frames leave `cmd_opa` and `cmd_opb` unchanged, so the previous operands are reused.
- ISSUE: `cmd_valid`=1; all `cmd_*` outputs are held stable. On `cmd_ready`=1, go to IDLE.
- A byte arriving in ISSUE is dropped and pulses `frame_err`. If `cmd_ready` is also 1 in that cycle, the handshake still completes.
- Byte values in non-IDLE states are never interpreted as opcodes: 0xAA in WR_DATA is data.
- Upper address and function bits beyond their widths are ignored.

## Timing
- Reset: state=IDLE. `cmd_valid`, `frame_err`, `cmd_type`, `cmd_addr`, `cmd_wdata`, `cmd_opa`, `cmd_opb` and `cmd_fun` are all 0.
- Reset mid-frame discards the partial frame immediately (asynchronous).
- All outputs are registered.
- `cmd_valid` rises the cycle after the `rx_valid` of the final frame byte.
- The handshake completes on the edge where `cmd_valid`=`cmd_ready`=1; `cmd_valid` is 0 the next cycle.
- Minimum command-to-command gap: an opcode byte can be accepted in the first cycle back in IDLE.
- `cmd_ready` already high when ISSUE is entered gives a one-cycle `cmd_valid`.
- `frame_err` is high exactly one cycle, in the cycle after the offending byte.

## Configuration
- `CMD_TIMEOUT_EN` defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B and ALU_FUN.
  - The counter clears on entry to these states and on every `rx_valid`.
  - When the counter reaches `TIMEOUT_CYCLES` without a byte, the state returns to IDLE and `frame_err` pulses once. Latched fields may hold partial values, but `cmd_valid` never asserts for that frame.
  - ISSUE never times out.
  - A byte and timeout in the same cycle: the byte wins.
- `CMD_TIMEOUT_EN` undefined: no counter. The parser waits indefinitely for the next byte.

## Test plan
- Reset, then bytes AA,05,3C with `cmd_ready`=1 → one-cycle `cmd_valid` after 0x3C; `cmd_type`=00, `cmd_addr`=5, `cmd_wdata`=0x3C.
- CC,12,34,01 with `cmd_ready`=0 for 4 cycles, then 1 → `cmd_valid` held for 5 cycles with stable values (type=10, opa=0x12, opb=0x34, fun=1). Then DD,02 → type=11, opa/opb still 0x12/0x34, fun=2.
- Byte 0x55 in IDLE, then BB,0F → `frame_err` pulses once for 0x55; read command with addr=0xF follows normally.
- With `cmd_ready`=0 in ISSUE, send byte 0xAA → byte dropped and `frame_err` pulses. After `cmd_ready`, state is IDLE and the next AA starts a new frame.
- `reset` asserted after AA,03 → all outputs 0 and state IDLE. Then a single byte 0x77 → `frame_err` (0x77 is not treated as write data).
- With `CMD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=10: send AA, then idle 10 cycles → `frame_err` pulse and return to IDLE with no `cmd_valid`. Repeat with a byte arriving in cycle 10 → no timeout.
